farbborg_scanner: RTL and testbench
===================================

FARBBORG_SCANNER -- requirements
Module: farbborg_scanner

Interface
REQ-001 Parameter PLANES, default 8: number of LED planes scanned per frame (1..32).
REQ-002 Parameter BASE, default 0: word address of plane 0 in the frame RAM; BASE + PLANES*16 SHALL be at most 512.
REQ-003 Parameter PRESCALE, default 4: clocks per PWM step (>=1).
REQ-004 Parameter BLANK_CYC, default 8: dead-time clocks between planes (>=1).
REQ-005 clk  input  1  single clock, shared with the frame RAM read port.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  scan enable; low forces blanking.
REQ-008 addrb  output  9  word read address to the frame RAM 32-bit port.
REQ-009 dob  input  32  read data, valid the clock after addrb is presented.
REQ-010 plane_sel  output  PLANES  one-hot plane driver; all zero while blanked.
REQ-011 col  output  64  channel drive, 1 = LED on.
REQ-012 frame_start  output  1  one-clock pulse when plane 0 begins FETCH.

Function
REQ-013 Each plane occupies 16 consecutive RAM words, i.e. 64 brightness bytes; plane p starts at word BASE + 16*p.
REQ-014 Byte order: dob[8k+7:8k] of word w is channel 4w+k, matching little-endian byte writes on the 8-bit port.
REQ-015 State machine states: BLANK, FETCH, PWM; reset enters BLANK with plane index 0.
REQ-016 BLANK: plane_sel = 0, col = 0 for exactly BLANK_CYC clocks, then FETCH if enable = 1; otherwise remain in BLANK.
REQ-017 FETCH: addrb = BASE + 16*plane + w for w = 0..15 on 16 consecutive clocks; word w is captured from dob one clock later; FETCH lasts 17 clocks, then PWM.
REQ-018 Captured brightness SHALL go to a shadow register bank; displayed values change only on the FETCH->PWM transition.
REQ-019 PWM: 8-bit pwm_cnt starts at 0 and increments every PRESCALE clocks up to 254; PWM lasts 255*PRESCALE clocks.
REQ-020 During PWM: plane_sel = one-hot(plane); col[i] = (bright[i] > pwm_cnt), registered; brightness 0 never lights, 255 is always lit.
REQ-021 At the end of PWM: go to BLANK; plane increments, wrapping from PLANES-1 to 0.
REQ-022 frame_start SHALL pulse for exactly one clock, on the first FETCH clock of plane 0.
REQ-023 enable = 0 in FETCH or PWM: on the next clock, state = BLANK with plane_sel = 0 and col = 0; plane index is unchanged, so re-enable rescans the same plane from FETCH after BLANK_CYC.
REQ-024 addrb holds its last value outside FETCH.
REQ-025 Plane period with enable held high = BLANK_CYC + 17 + 255*PRESCALE clocks; frame period = PLANES times that.

Reset
REQ-026 Synchronous reset, active-high, dominant over enable and any state.
REQ-027 Reset values: state BLANK, plane 0, pwm_cnt 0, addrb 0, plane_sel 0, col 0, frame_start 0, shadow bank all 0.
REQ-028 Reset asserted mid-FETCH or mid-PWM: outputs are at reset values on the following clock; the first frame_start comes BLANK_CYC clocks after reset release with enable = 1.

Verification
REQ-029 Reset release, enable=1, defaults -> frame_start at clock 8; addrb = 0..15 on clocks 8..23; plane_sel = 8'h01 from clock 25.
REQ-030 RAM word 0 = 32'h87654321, PRESCALE=1 -> col[0] high for 33 PWM clocks; col[1], col[2], col[3] high for 67, 101, 135 clocks.
REQ-031 Channels preset to 0 and 255 -> col bit always 0, and the other bit high for the entire PWM phase, never during BLANK or FETCH.
REQ-032 PLANES=8 full run -> plane_sel walks 01,02,...,80,01; frame_start spacing = 8*(8+17+255*PRESCALE) clocks; plane 1 reads words 16..31.
REQ-033 Drop enable mid-PWM of plane 3, restore 100 clocks later -> all outputs 0 on the next clock; plane 3 is refetched (addrb 48..63) after 8 BLANK clocks.
REQ-034 Assert reset mid-FETCH -> outputs 0 on the next clock; after release, addrb restarts at BASE.

Source files
------------

// File: rtl/farbborg_scanner.sv
`default_nettype none
// ============================================================================
// farbborg_scanner: multiplexed LED-cube plane scanner with 8-bit PWM per channel
// Revision: 1.0
// ============================================================================
module farbborg_scanner #(
  parameter int PLANES    = 8,
  parameter int BASE      = 0,
  parameter int PRESCALE  = 4,
  parameter int BLANK_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [8:0]        addrb,
  input  logic [31:0]       dob,
  output logic [PLANES-1:0] plane_sel,
  output logic [63:0]       col,
  output logic              frame_start
);

  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [8:0]         C_BASE       = 9'(BASE);
  localparam logic [PLANE_W-1:0] C_PLANE_LAST = PLANE_W'(PLANES - 1);
  localparam logic [PLANE_W-1:0] C_PLANE_ONE  = PLANE_W'(1);
  localparam logic [PRE_W-1:0]   C_PRE_MAX    = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]   C_PRE_ONE    = PRE_W'(1);
  localparam logic [BLK_W-1:0]   C_BLK_MAX    = BLK_W'(BLANK_CYC - 1);
  localparam logic [BLK_W-1:0]   C_BLK_ONE    = BLK_W'(1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_FETCH = 2'd1,
    ST_PWM   = 2'd2
  } state_t;

  state_t              state_q;
  logic [PLANE_W-1:0]  plane_q;
  logic [BLK_W-1:0]    blk_q;
  logic [4:0]          fetch_q;
  logic [PRE_W-1:0]    pre_q;
  logic [7:0]          pwm_q;
  logic [8:0]          addrb_q;
  logic [PLANES-1:0]   plane_sel_q;
  logic [63:0]         col_q;
  logic                frame_start_q;
  logic [479:0]        shadow_q;
  logic [511:0]        disp_q;

  logic [7:0]          pwm_d;
  logic [63:0]         lit_d;
  logic [511:0]        fetched_w;
  logic [511:0]        bright_w;
  logic [PLANES-1:0]   onehot_w;
  logic [8:0]          plane_base_w;
  logic [3:0]          cap_w;

  // Word 15 arrives on the FETCH->PWM edge itself, so it bypasses the shadow bank.
  assign fetched_w    = {dob, shadow_q};
  assign plane_base_w = C_BASE + 9'({plane_q, 4'b0000});
  assign cap_w        = fetch_q[3:0] - 4'd1;

  always_comb begin
    pwm_d = 8'd0;
    if (state_q == ST_PWM) begin
      pwm_d = (pre_q == C_PRE_MAX) ? pwm_q + 8'd1 : pwm_q;
    end
  end

  // Next col value uses the bank that will be displayed after this edge.
  always_comb begin
    bright_w = (state_q == ST_FETCH) ? fetched_w : disp_q;
    for (int i = 0; i < 64; i++) begin
      lit_d[i] = bright_w[8*i +: 8] > pwm_d;
    end
  end

  always_comb begin
    onehot_w = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (plane_q == PLANE_W'(i)) onehot_w[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      plane_q       <= '0;
      blk_q         <= '0;
      fetch_q       <= 5'd0;
      pre_q         <= '0;
      pwm_q         <= 8'd0;
      addrb_q       <= 9'd0;
      plane_sel_q   <= '0;
      col_q         <= 64'd0;
      frame_start_q <= 1'b0;
      shadow_q      <= '0;
      disp_q        <= '0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        ST_BLANK: begin
          plane_sel_q <= '0;
          col_q       <= 64'd0;
          if (!enable) begin
            blk_q <= '0;
          end else if (blk_q == C_BLK_MAX) begin
            blk_q         <= '0;
            state_q       <= ST_FETCH;
            fetch_q       <= 5'd0;
            addrb_q       <= plane_base_w;
            frame_start_q <= (plane_q == '0);
          end else begin
            blk_q <= blk_q + C_BLK_ONE;
          end
        end

        ST_FETCH: begin
          if (!enable) begin
            state_q <= ST_BLANK;
            blk_q   <= '0;
          end else begin
            if (fetch_q != 5'd0 && fetch_q != 5'd16) begin
              shadow_q[{cap_w, 5'd0} +: 32] <= dob;
            end
            if (fetch_q == 5'd16) begin
              state_q     <= ST_PWM;
              disp_q      <= fetched_w;
              col_q       <= lit_d;
              plane_sel_q <= onehot_w;
              pwm_q       <= 8'd0;
              pre_q       <= '0;
            end else begin
              fetch_q <= fetch_q + 5'd1;
              if (fetch_q < 5'd15) addrb_q <= addrb_q + 9'd1;
            end
          end
        end

        ST_PWM: begin
          if (!enable) begin
            state_q     <= ST_BLANK;
            blk_q       <= '0;
            plane_sel_q <= '0;
            col_q       <= 64'd0;
          end else if (pwm_q == 8'd254 && pre_q == C_PRE_MAX) begin
            state_q     <= ST_BLANK;
            blk_q       <= '0;
            plane_sel_q <= '0;
            col_q       <= 64'd0;
            plane_q     <= (plane_q == C_PLANE_LAST) ? '0 : plane_q + C_PLANE_ONE;
          end else begin
            col_q <= lit_d;
            pwm_q <= pwm_d;
            pre_q <= (pre_q == C_PRE_MAX) ? '0 : pre_q + C_PRE_ONE;
          end
        end

        default: begin
          state_q <= ST_BLANK;
        end
      endcase
    end
  end

  assign addrb       = addrb_q;
  assign plane_sel   = plane_sel_q;
  assign col         = col_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_farbborg_scanner.sv
`default_nettype none
// ============================================================================
// tb_farbborg_scanner: randomized frame RAM, timeline model of the plane scan
// Revision: 1.0
// ============================================================================
module tb_farbborg_scanner;

  localparam int PLANES    = 8;
  localparam int BASE      = 0;
  localparam int PRESCALE  = 2;
  localparam int BLANK_CYC = 8;
  localparam int PER       = BLANK_CYC + 17 + 255 * PRESCALE;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [8:0]        addrb;
  logic [31:0]       dob;
  logic [PLANES-1:0] plane_sel;
  logic [63:0]       col;
  logic              frame_start;

  logic [31:0] mem [512];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) dob <= mem[addrb];

  farbborg_scanner #(
    .PLANES(PLANES), .BASE(BASE), .PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .addrb(addrb), .dob(dob),
    .plane_sel(plane_sel), .col(col), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [PLANES-1:0] sel;
    logic [63:0]       col;
    logic              fs;
    logic              fetching;
    logic [8:0]        addr;
  } exp_t;

  function automatic logic [7:0] bright(int p, int ch);
    logic [31:0] w;
    w = mem[BASE + 16 * p + ch / 4];
    return w[8 * (ch % 4) +: 8];
  endfunction

  // t counts clocks since the BLANK phase of plane 0 began with enable held high.
  function automatic exp_t model(int t);
    exp_t e;
    int p, w, j;
    e = '0;
    p = (t / PER) % PLANES;
    w = t % PER;
    if (w >= BLANK_CYC && w < BLANK_CYC + 17) begin
      e.fetching = 1'b1;
      e.addr     = 9'(BASE + 16 * p + (((w - BLANK_CYC) < 16) ? (w - BLANK_CYC) : 15));
      e.fs       = (w == BLANK_CYC) && (p == 0);
    end else if (w >= BLANK_CYC + 17) begin
      j = (w - BLANK_CYC - 17) / PRESCALE;
      e.sel[p] = 1'b1;
      for (int i = 0; i < 64; i++) e.col[i] = (int'(bright(p, i)) > j);
    end
    return e;
  endfunction

  // Leaves the bench at the sampling point of cycle 'target' after reset release.
  task automatic start_run(input int target);
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (target) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (addrb !== 9'd0) begin n_fail++; $display("FAIL reset_addrb got=%h exp=000", addrb); end
    n_checks++;
    if (plane_sel !== '0) begin n_fail++; $display("FAIL reset_plane_sel got=%h exp=0", plane_sel); end
    n_checks++;
    if (col !== 64'd0) begin n_fail++; $display("FAIL reset_col got=%h exp=0", col); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
  endtask

  task automatic test_full_frame();
    exp_t e;
    logic [8:0] hold;
    int on_cnt[8];
    int exp_on[8];
    int fs_first, fs_gap;
    logic [PLANES-1:0] prev_sel;
    logic [PLANES-1:0] walk[$];
    int t_end;
    exp_on = '{33*PRESCALE, 67*PRESCALE, 101*PRESCALE, 135*PRESCALE,
               255*PRESCALE, 0, 255*PRESCALE, 0};
    for (int i = 0; i < 8; i++) on_cnt[i] = 0;
    hold = 9'd0;
    fs_first = -1;
    fs_gap = -1;
    prev_sel = '0;
    t_end = PLANES * PER + BLANK_CYC + 30;
    start_run(0);
    for (int t = 0; t <= t_end; t++) begin
      e = model(t);
      if (e.fetching) hold = e.addr;
      n_checks++;
      if (addrb !== hold) begin n_fail++; $display("FAIL frame_addrb cyc=%0d got=%h exp=%h", t, addrb, hold); end
      n_checks++;
      if (plane_sel !== e.sel) begin n_fail++; $display("FAIL frame_plane_sel cyc=%0d got=%h exp=%h", t, plane_sel, e.sel); end
      n_checks++;
      if (col !== e.col) begin n_fail++; $display("FAIL frame_col cyc=%0d got=%h exp=%h", t, col, e.col); end
      n_checks++;
      if (frame_start !== e.fs) begin n_fail++; $display("FAIL frame_start cyc=%0d got=%b exp=%b", t, frame_start, e.fs); end
      if (frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = t;
        else if (fs_gap < 0) fs_gap = t - fs_first;
      end
      if (plane_sel !== prev_sel && plane_sel !== '0) walk.push_back(plane_sel);
      prev_sel = plane_sel;
      if (t < PER) for (int i = 0; i < 8; i++) on_cnt[i] += int'(col[i]);
      @(negedge clk);
    end
    n_checks++;
    if (fs_gap !== PLANES * PER) begin n_fail++; $display("FAIL frame_period got=%0d exp=%0d", fs_gap, PLANES * PER); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (on_cnt[i] !== exp_on[i]) begin n_fail++; $display("FAIL on_time ch=%0d got=%0d exp=%0d", i, on_cnt[i], exp_on[i]); end
    end
    n_checks++;
    if (walk.size() !== PLANES + 1) begin
      n_fail++; $display("FAIL plane_walk_len got=%0d exp=%0d", walk.size(), PLANES + 1);
    end else begin
      for (int i = 0; i <= PLANES; i++) begin
        n_checks++;
        if (walk[i] !== PLANES'(1 << (i % PLANES))) begin
          n_fail++; $display("FAIL plane_walk idx=%0d got=%h exp=%h", i, walk[i], PLANES'(1 << (i % PLANES)));
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    logic [8:0] hold;
    int t_drop;
    t_drop = 3 * PER + BLANK_CYC + 17 + 100;
    start_run(t_drop);
    n_checks++;
    if (plane_sel !== PLANES'(8)) begin n_fail++; $display("FAIL drop_pre_sel got=%h exp=08", plane_sel); end
    enable = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({plane_sel, col, frame_start} !== '0) begin
        n_fail++; $display("FAIL drop_blank cyc=+%0d got sel=%h col=%h fs=%b exp all 0", i, plane_sel, col, frame_start);
      end
      n_checks++;
      if (addrb !== 9'(BASE + 63)) begin n_fail++; $display("FAIL drop_addr_hold cyc=+%0d got=%h exp=%h", i, addrb, 9'(BASE + 63)); end
    end
    enable = 1'b1;
    hold = 9'(BASE + 63);
    for (int j = 0; j < BLANK_CYC + 17 + 40; j++) begin
      e = model(3 * PER + j);
      if (e.fetching) hold = e.addr;
      n_checks++;
      if (addrb !== hold) begin n_fail++; $display("FAIL refetch_addrb j=%0d got=%h exp=%h", j, addrb, hold); end
      n_checks++;
      if (plane_sel !== e.sel) begin n_fail++; $display("FAIL refetch_sel j=%0d got=%h exp=%h", j, plane_sel, e.sel); end
      n_checks++;
      if (col !== e.col || frame_start !== e.fs) begin
        n_fail++; $display("FAIL refetch_col j=%0d got=%h/%b exp=%h/%b", j, col, frame_start, e.col, e.fs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_fetch();
    exp_t e;
    logic [8:0] hold;
    start_run(PER + BLANK_CYC + 5);
    n_checks++;
    if (addrb !== 9'(BASE + 21)) begin n_fail++; $display("FAIL midfetch_addr got=%h exp=%h", addrb, 9'(BASE + 21)); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({addrb, plane_sel, col, frame_start} !== '0) begin
      n_fail++; $display("FAIL midfetch_reset got addr=%h sel=%h col=%h fs=%b exp all 0", addrb, plane_sel, col, frame_start);
    end
    @(negedge clk);
    reset = 1'b0;
    hold = 9'd0;
    for (int t = 0; t < BLANK_CYC + 17 + 6; t++) begin
      e = model(t);
      if (e.fetching) hold = e.addr;
      n_checks++;
      if (addrb !== hold || frame_start !== e.fs) begin
        n_fail++; $display("FAIL restart cyc=%0d got addr=%h fs=%b exp addr=%h fs=%b", t, addrb, frame_start, hold, e.fs);
      end
      n_checks++;
      if (plane_sel !== e.sel || col !== e.col) begin
        n_fail++; $display("FAIL restart_out cyc=%0d got sel=%h col=%h exp sel=%h col=%h", t, plane_sel, col, e.sel, e.col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_pwm();
    start_run(BLANK_CYC + 17 + 50);
    n_checks++;
    if (plane_sel !== PLANES'(1)) begin n_fail++; $display("FAIL midpwm_pre_sel got=%h exp=01", plane_sel); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({addrb, plane_sel, col, frame_start} !== '0) begin
      n_fail++; $display("FAIL midpwm_reset got addr=%h sel=%h col=%h fs=%b exp all 0", addrb, plane_sel, col, frame_start);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[BASE]     = 32'h8765_4321;
    mem[BASE + 1] = 32'h00FF_00FF;
    for (int n = 0; n < 24; n++) begin
      int wi, bi;
      logic [31:0] tmp;
      wi = $urandom_range(BASE + 2, BASE + 16 * PLANES - 1);
      bi = $urandom_range(0, 3);
      tmp = mem[wi];
      tmp[8 * bi +: 8] = (n % 2 == 1) ? 8'hFF : 8'h00;
      mem[wi] = tmp;
    end
    test_reset();
    test_full_frame();
    test_enable_drop();
    test_reset_mid_fetch();
    test_reset_mid_pwm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
